// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

    typedef enum logic [0:0] {
        PC_RUN   = 1'b0,
        PC_FLUSH = 1'b1
    } pc_state_e;

endpackage

// File: rtl/pipe_ctrl_sat_cnt.sv
// Saturating up-counter with synchronous reset and clear; clear beats increment.
module sat_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (inc && (cnt_q != '1))
            cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign q = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: merges stall and flush requests with a stall watchdog
// into per-stage hold/bubble vectors, plus a saturating stall-cycle counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned NSTAGE        = 5,
    parameter int unsigned FLUSH_LEN     = 2,
    parameter int unsigned STALL_TIMEOUT = 64,
    parameter int unsigned CNT_W         = 32
) (
    input  logic                      cpu_clk,
    input  logic                      cpu_rst,
    input  logic [NSTAGE-1:0]         stallreq,
    input  logic                      flush_req,
    input  logic [$clog2(NSTAGE)-1:0] flush_stage,
    input  logic                      perf_clr,
    output logic [NSTAGE-1:0]         stall,
    output logic [NSTAGE-1:0]         flush,
    output logic                      timeout,
    output logic [CNT_W-1:0]          stall_cycles
);

    localparam int unsigned SW  = $clog2(NSTAGE);
    localparam int unsigned FCW = $clog2(FLUSH_LEN + 1);
    localparam int unsigned WDW = (STALL_TIMEOUT == 0) ? 1 : $clog2(STALL_TIMEOUT + 1);

    localparam logic [SW-1:0]  LAST_STG  = SW'(NSTAGE - 1);
    localparam logic [FCW-1:0] FL_FULL   = FCW'(FLUSH_LEN);
    localparam logic [FCW-1:0] FL_RELOAD = FCW'(FLUSH_LEN - 1);
    localparam logic [WDW-1:0] WD_LIMIT  = (STALL_TIMEOUT == 0) ? '0 : WDW'(STALL_TIMEOUT - 1);

    function automatic logic [SW-1:0] hi_idx(input logic [NSTAGE-1:0] v);
        logic [SW-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < NSTAGE; i++)
            if (v[i]) idx = SW'(i);
        return idx;
    endfunction

    function automatic logic [NSTAGE-1:0] therm(input logic [SW-1:0] hi);
        logic [NSTAGE-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < NSTAGE; i++)
            m[i] = (SW'(i) <= hi);
        return m;
    endfunction

    pc_state_e         state_q, state_d;
    logic [SW-1:0]     fl_stage_q, fl_stage_d;
    logic [FCW-1:0]    fl_cnt_q, fl_cnt_d;
    logic              timeout_q, timeout_d;

    logic [SW-1:0]     fs_clamp;
    logic [SW-1:0]     merged_stg;
    logic [NSTAGE-1:0] stall_c;
    logic [NSTAGE-1:0] flush_c;
    logic [WDW-1:0]    wd_q;
    logic              wd_fire;

    assign fs_clamp = (32'(flush_stage) >= NSTAGE) ? LAST_STG : flush_stage;

    // Threshold keys on the raw request so a same-cycle flush_req cannot mask the watchdog.
    assign wd_fire = (STALL_TIMEOUT != 0) && (state_q == PC_RUN) &&
                     (|stallreq) && (wd_q == WD_LIMIT);

    always_comb begin
        state_d    = state_q;
        fl_stage_d = fl_stage_q;
        fl_cnt_d   = fl_cnt_q;
        timeout_d  = 1'b0;
        stall_c    = '0;
        flush_c    = '0;
        merged_stg = fl_stage_q;

        case (state_q)
            PC_RUN: begin
                if (flush_req) begin
                    flush_c = therm(fs_clamp);
                    if (FLUSH_LEN > 1) begin
                        state_d    = PC_FLUSH;
                        fl_stage_d = fs_clamp;
                        fl_cnt_d   = FL_RELOAD;
                    end
                end else if (|stallreq) begin
                    stall_c = therm(hi_idx(stallreq));
                    flush_c = {stall_c[NSTAGE-2:0], 1'b0} & ~stall_c;
                end
                if (wd_fire) begin
                    state_d    = PC_FLUSH;
                    fl_stage_d = LAST_STG;
                    fl_cnt_d   = FL_FULL;
                    timeout_d  = 1'b1;
                end
            end
            PC_FLUSH: begin
                if (flush_req && (fs_clamp > fl_stage_q))
                    merged_stg = fs_clamp;
                flush_c    = therm(merged_stg);
                fl_stage_d = merged_stg;
                if (flush_req && (FLUSH_LEN > 1))
                    fl_cnt_d = FL_RELOAD;
                else if (fl_cnt_q <= FCW'(1))
                    state_d = PC_RUN;
                else
                    fl_cnt_d = fl_cnt_q - FCW'(1);
            end
            default: state_d = PC_RUN;
        endcase
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state_q    <= PC_RUN;
            fl_stage_q <= '0;
            fl_cnt_q   <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fl_stage_q <= fl_stage_d;
            fl_cnt_q   <= fl_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    sat_cnt #(.W(WDW)) u_wd_cnt (
        .clk (cpu_clk),
        .rst (cpu_rst),
        .clr (~|stall_c),
        .inc (|stall_c),
        .q   (wd_q)
    );

    sat_cnt #(.W(CNT_W)) u_stall_cnt (
        .clk (cpu_clk),
        .rst (cpu_rst),
        .clr (perf_clr),
        .inc (|stall_c),
        .q   (stall_cycles)
    );

    assign stall   = stall_c;
    assign flush   = flush_c;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: NSTAGE=5, FLUSH_LEN=2, STALL_TIMEOUT=8, CNT_W=8, plus a watchdog-off copy.
module tb_pipe_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] stallreq;
    logic       flush_req;
    logic [2:0] flush_stage;
    logic       perf_clr;

    logic [4:0] stall, flush, stall0, flush0;
    logic       timeout, timeout0;
    logic [7:0] stall_cycles, stall_cycles0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.NSTAGE(5), .FLUSH_LEN(2), .STALL_TIMEOUT(8), .CNT_W(8)) dut (
        .cpu_clk(clk), .cpu_rst(rst), .stallreq(stallreq), .flush_req(flush_req),
        .flush_stage(flush_stage), .perf_clr(perf_clr), .stall(stall), .flush(flush),
        .timeout(timeout), .stall_cycles(stall_cycles)
    );

    pipe_ctrl #(.NSTAGE(5), .FLUSH_LEN(2), .STALL_TIMEOUT(0), .CNT_W(8)) dut0 (
        .cpu_clk(clk), .cpu_rst(rst), .stallreq(stallreq), .flush_req(flush_req),
        .flush_stage(flush_stage), .perf_clr(perf_clr), .stall(stall0), .flush(flush0),
        .timeout(timeout0), .stall_cycles(stall_cycles0)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs at the falling edge and let combinational outputs settle.
    task automatic cyc(input logic [4:0] sr, input logic fr, input logic [2:0] fs, input logic pc);
        @(negedge clk);
        stallreq    = sr;
        flush_req   = fr;
        flush_stage = fs;
        perf_clr    = pc;
        #1;
    endtask

    task automatic chk_sf(input string tag, input logic [4:0] es, input logic [4:0] ef);
        chk({tag, ".stall"}, 32'(stall), 32'(es));
        chk({tag, ".flush"}, 32'(flush), 32'(ef));
    endtask

    initial begin
        rst = 1'b1; stallreq = '0; flush_req = 1'b0; flush_stage = '0; perf_clr = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk_sf("reset", 5'b00000, 5'b00000);
        chk("reset.timeout", 32'(timeout), 32'd0);
        chk("reset.cnt", 32'(stall_cycles), 32'd0);
        rst = 1'b0;

        // Stall merge with bubble behind the hold
        cyc(5'b00100, 1'b0, 3'd0, 1'b0); chk_sf("stall_k2", 5'b00111, 5'b01000);
        cyc(5'b10000, 1'b0, 3'd0, 1'b0); chk_sf("stall_k4", 5'b11111, 5'b00000);

        // Flush beats stall, lasts two cycles
        cyc(5'b00110, 1'b1, 3'd2, 1'b0); chk_sf("flush_c1", 5'b00000, 5'b00111);
        cyc(5'b11111, 1'b0, 3'd0, 1'b0); chk_sf("flush_c2", 5'b00000, 5'b00111);
        cyc(5'b11111, 1'b0, 3'd0, 1'b0); chk_sf("flush_run", 5'b11111, 5'b00000);
        cyc(5'b00000, 1'b0, 3'd0, 1'b0); chk_sf("idle", 5'b00000, 5'b00000);
        chk("cnt_after3", 32'(stall_cycles), 32'd3);

        // Watchdog: 8 stall cycles, then forced full flush for 2 cycles
        for (int i = 1; i <= 11; i++) begin
            cyc(5'b00010, 1'b0, 3'd0, 1'b0);
            if (i <= 8 || i == 11) begin
                chk_sf($sformatf("wd_stall%0d", i), 5'b00011, 5'b00100);
                chk($sformatf("wd_to%0d", i), 32'(timeout), 32'd0);
            end else begin
                chk_sf($sformatf("wd_flush%0d", i), 5'b00000, 5'b11111);
                chk($sformatf("wd_to%0d", i), 32'(timeout), (i == 9) ? 32'd1 : 32'd0);
            end
        end
        cyc(5'b00000, 1'b0, 3'd0, 1'b0);

        // Flush extended and widened by a second request
        cyc(5'b00000, 1'b1, 3'd1, 1'b0); chk_sf("merge_c1", 5'b00000, 5'b00011);
        cyc(5'b00000, 1'b1, 3'd3, 1'b0); chk_sf("merge_c2", 5'b00000, 5'b01111);
        cyc(5'b00000, 1'b0, 3'd0, 1'b0); chk_sf("merge_c3", 5'b00000, 5'b01111);
        cyc(5'b00001, 1'b0, 3'd0, 1'b0); chk_sf("merge_run", 5'b00001, 5'b00010);

        // Out-of-range flush_stage clamps to the last stage
        cyc(5'b00000, 1'b1, 3'd7, 1'b0); chk_sf("clamp_c1", 5'b00000, 5'b11111);
        cyc(5'b00000, 1'b0, 3'd0, 1'b0); chk_sf("clamp_c2", 5'b00000, 5'b11111);
        cyc(5'b00000, 1'b0, 3'd0, 1'b0); chk_sf("clamp_end", 5'b00000, 5'b00000);

        // Reset while flushing with a nonzero counter
        cyc(5'b00000, 1'b0, 3'd0, 1'b1);
        for (int i = 0; i < 5; i++) cyc(5'b00001, 1'b0, 3'd0, 1'b0);
        cyc(5'b00000, 1'b1, 3'd2, 1'b0);
        chk("cnt_before_rst", 32'(stall_cycles), 32'd5);
        rst = 1'b1;
        cyc(5'b00000, 1'b0, 3'd0, 1'b0);
        rst = 1'b0;
        cyc(5'b00000, 1'b0, 3'd0, 1'b0);
        chk_sf("rst_mid", 5'b00000, 5'b00000);
        chk("rst_mid.timeout", 32'(timeout), 32'd0);
        chk("rst_mid.cnt", 32'(stall_cycles), 32'd0);
        cyc(5'b00100, 1'b0, 3'd0, 1'b0); chk_sf("rst_after", 5'b00111, 5'b01000);

        // Watchdog disabled: counter saturates, then perf_clr
        for (int i = 0; i < 300; i++) cyc(5'b00001, 1'b0, 3'd0, 1'b0);
        chk("nowd.stall", 32'(stall0), 32'h01);
        chk("nowd.timeout", 32'(timeout0), 32'd0);
        chk("sat.cnt", 32'(stall_cycles0), 32'd255);
        cyc(5'b00001, 1'b0, 3'd0, 1'b1);
        chk("sat.hold", 32'(stall_cycles0), 32'd255);
        cyc(5'b00001, 1'b0, 3'd0, 1'b0);
        chk("clr.zero", 32'(stall_cycles0), 32'd0);
        cyc(5'b00001, 1'b0, 3'd0, 1'b0);
        chk("clr.one", 32'(stall_cycles0), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
